// File: rtl/acc_4bit_seq_if.sv
// ---------------------------------------------------------------------------
// acc_4bit_seq_if
//   Command push channel into the accumulator sequencer.
//   master : command producer (drives in_valid / in_ctrl / in_b / in_rpt)
//   slave  : sequencer (drives in_ready)
//   A command is accepted on a rising clk edge with in_valid && in_ready.
// ---------------------------------------------------------------------------
interface acc_4bit_seq_if #(
    parameter int RPT_W = 4
);
    logic             in_valid;   // push request
    logic             in_ready;   // FIFO not full
    logic [4:0]       in_ctrl;    // accumulator {m,s}
    logic [3:0]       in_b;       // accumulator operand
    logic [RPT_W-1:0] in_rpt;     // command issued in_rpt+1 cycles

    modport master (
        output in_valid, in_ctrl, in_b, in_rpt,
        input  in_ready
    );

    modport slave (
        input  in_valid, in_ctrl, in_b, in_rpt,
        output in_ready
    );
endinterface

// File: rtl/acc_4bit_seq.sv
// ---------------------------------------------------------------------------
// acc_4bit_seq
//   Command sequencer sitting directly upstream of the 4-bit accumulator.
//   Commands {ctrl, b, rpt} are buffered in a DEPTH-entry FIFO. On start the
//   head command is driven onto ctrl/b for rpt+1 consecutive cycles, then the
//   next one follows with no bubble. While not issuing, NOP_CTRL is driven so
//   the accumulator holds its value. The accumulator's carry-out is counted
//   (saturating) and can optionally halt issue.
//
// Ports
//   clk, rst_n   clock / asynchronous active-low reset
//   cmd          command push channel (slave side of acc_4bit_seq_if)
//   start        pulse: begin issuing from IDLE, resume from HALT
//   clear        pulse: flush FIFO, return to IDLE (wins over everything)
//   halt_en      stop issuing after an op that produced a carry
//   acc_cout     accumulator carry-out for the op driven this cycle
//   ctrl, b      accumulator control / operand
//   issue        ctrl/b carry a real command this cycle
//   busy/halted  state is RUN / HALT
//   done         one-cycle pulse alongside the final issued op
//   cout_cnt     saturating count of carries seen on issue cycles
//   level        FIFO occupancy 0..DEPTH
// ---------------------------------------------------------------------------
module acc_4bit_seq #(
    parameter int         DEPTH    = 8,
    parameter int         RPT_W    = 4,
    parameter logic [4:0] NOP_CTRL = 5'b11111
) (
    input  logic                     clk,
    input  logic                     rst_n,
    acc_4bit_seq_if.slave            cmd,
    input  logic                     start,
    input  logic                     clear,
    input  logic                     halt_en,
    input  logic                     acc_cout,
    output logic [4:0]               ctrl,
    output logic [3:0]               b,
    output logic                     issue,
    output logic                     busy,
    output logic                     halted,
    output logic                     done,
    output logic [7:0]               cout_cnt,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int            AW       = $clog2(DEPTH);
    localparam logic [AW:0]   LVL_FULL = (AW+1)'(DEPTH);
    localparam logic [AW:0]   LVL_ONE  = (AW+1)'(1);

    typedef struct packed {
        logic [4:0]       ctrl;
        logic [3:0]       b;
        logic [RPT_W-1:0] rpt;
    } cmd_t;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_HALT = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_next;

    cmd_t             r_mem [DEPTH];
    logic [AW-1:0]    r_wptr;
    logic [AW-1:0]    r_rptr;
    logic [AW:0]      r_level;
    logic [RPT_W-1:0] r_rpt;
    logic [7:0]       r_cout_cnt;

    logic [AW-1:0]    w_rptr_nxt;
    cmd_t             w_head;
    logic [RPT_W-1:0] w_rpt_nxt;
    logic             w_full;
    logic             w_push;
    logic             w_run;
    logic             w_pop;
    logic             w_last;

    // -----------------------------------------------------------------------
    // FIFO status / handshake
    // -----------------------------------------------------------------------
    // in_ready looks at the registered level only, so a pop in the same
    // cycle never opens a slot for a push while full.
    assign w_full       = (r_level == LVL_FULL);
    assign cmd.in_ready = !w_full;
    assign w_push       = cmd.in_valid && !w_full && !clear;

    assign w_rptr_nxt   = r_rptr + 1'b1;     // wraps: DEPTH is a power of 2
    assign w_head       = r_mem[r_rptr];
    assign w_rpt_nxt    = r_mem[w_rptr_nxt].rpt;

    assign w_run        = (r_state == S_RUN);
    // Head retires once its repeat count is exhausted.
    assign w_pop        = w_run && (r_rpt == '0) && !clear;
    // Last op: the pop empties the FIFO. A same-cycle push lands in the FIFO
    // but is not picked up by this run.
    assign w_last       = w_pop && (r_level == LVL_ONE);

    // -----------------------------------------------------------------------
    // FSM: state register
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    // -----------------------------------------------------------------------
    // FSM: next state
    // -----------------------------------------------------------------------
    always_comb begin
        w_next = r_state;
        if (clear) begin
            w_next = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: if (start && (r_level != '0)) w_next = S_RUN;
                // The carrying op still counts as issued; if it was the
                // final one the run simply ends instead of halting.
                S_RUN: begin
                    if (w_last)                   w_next = S_IDLE;
                    else if (acc_cout && halt_en) w_next = S_HALT;
                end
                S_HALT: if (start) w_next = S_RUN;
                default: w_next = S_IDLE;
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // FSM: outputs (combinational from state and FIFO head)
    // -----------------------------------------------------------------------
    always_comb begin
        ctrl   = NOP_CTRL;
        b      = 4'd0;
        issue  = 1'b0;
        busy   = 1'b0;
        halted = 1'b0;
        done   = 1'b0;
        case (r_state)
            S_RUN: begin
                ctrl  = w_head.ctrl;
                b     = w_head.b;
                issue = 1'b1;
                busy  = 1'b1;
                done  = w_last;
            end
            S_HALT:  halted = 1'b1;
            default: ;
        endcase
    end

    // -----------------------------------------------------------------------
    // FIFO storage (data only, no reset needed: never read while empty)
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wptr] <= '{ctrl: cmd.in_ctrl, b: cmd.in_b, rpt: cmd.in_rpt};
    end

    // -----------------------------------------------------------------------
    // FIFO pointers and occupancy
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_level <= '0;
        end else if (clear) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_level <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + 1'b1;
            if (w_pop)  r_rptr <= w_rptr_nxt;
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: ;
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // Repeat counter: remaining extra cycles for the current head.
    // Held while halted so a resume continues mid-command.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rpt <= '0;
        end else if (clear) begin
            r_rpt <= '0;
        end else if ((r_state == S_IDLE) && (w_next == S_RUN)) begin
            r_rpt <= w_head.rpt;
        end else if (w_run) begin
            if (r_rpt != '0)         r_rpt <= r_rpt - 1'b1;
            else if (r_level > LVL_ONE) r_rpt <= w_rpt_nxt;
            else                     r_rpt <= '0;
        end
    end

    // -----------------------------------------------------------------------
    // Carry event counter: saturates, only reset clears it
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cout_cnt <= 8'd0;
        end else if (w_run && acc_cout && (r_cout_cnt != 8'hFF)) begin
            r_cout_cnt <= r_cout_cnt + 8'd1;
        end
    end

    assign cout_cnt = r_cout_cnt;
    assign level    = r_level;

endmodule

// File: doc/acc_4bit_seq.md
Name: acc_4bit_seq

Overview:
- Command sequencer directly upstream of the 4-bit accumulator.
- Buffers {ctrl, b, repeat} commands in a small FIFO and drives the accumulator's ctrl[4:0]/b[3:0] inputs one operation per clock on start.
- Monitors the accumulator's carry-out, counts carry events and can halt on carry; when not issuing it drives a hold (NOP) operation so the accumulator keeps its value.

Parameters:
- DEPTH, 8, command FIFO entries (power of 2, ≥2).
- RPT_W, 4, width of per-command repeat field.
- NOP_CTRL, 5'b11111, ctrl code driven when not issuing ({m,s} = logic mode, F=A → accumulator holds).

Ports:
- clk  in  1  clock, all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  command push request.
- in_ready  out  1  FIFO can accept (= !full).
- in_ctrl  in  5  command {m,s}.
- in_b  in  4  command operand.
- in_rpt  in  RPT_W  command issued in_rpt+1 consecutive cycles.
- start  in  1  pulse: begin/resume issuing.
- clear  in  1  pulse: flush FIFO, return to IDLE.
- halt_en  in  1  halt on accumulator carry.
- acc_cout  in  1  accumulator carry-out (active high), same-cycle response to driven op.
- ctrl  out  5  to accumulator ctrl.
- b  out  4  to accumulator b.
- issue  out  1  high when ctrl/b carry a real command this cycle.
- busy  out  1  state is RUN.
- halted  out  1  state is HALT.
- done  out  1  one-cycle pulse when last command completes.
- cout_cnt  out  8  saturating count of carry events during issue cycles.
- level  out  $clog2(DEPTH)+1  FIFO occupancy.

Behaviour:
- Reset (async, rst_n=0): state IDLE, FIFO empty, level=0, in_ready=1, ctrl=NOP_CTRL, b=0, issue=0, busy=0, halted=0, done=0, cout_cnt=0, repeat counter=0.
- Push: in_valid && in_ready at posedge writes {in_ctrl,in_b,in_rpt} at tail. in_ready = !full, combinational from level only; a pop in the same cycle does not enable a push when full. Push and pop in the same cycle when not full: level unchanged.
- ctrl/b/issue are combinational from state and FIFO head. RUN: ctrl=head.ctrl, b=head.b, issue=1. IDLE/HALT: ctrl=NOP_CTRL, b=0, issue=0.
- States:
  - IDLE: start && level≠0 → RUN; repeat counter loaded with head.rpt on entry. start with empty FIFO is ignored.
  - RUN: each cycle one op is issued (accumulator commits it at the same posedge).
    - Repeat counter ≠0 → decrement.
    - Counter =0 → pop head and load next head's rpt (a command pushed this same cycle into an empty slot is not visible until the next cycle).
    - Pop leaves FIFO empty → done=1 for one cycle, → IDLE.
  - RUN halt: if acc_cout=1 and halt_en=1 at a posedge, the op still counts as issued (counter/pop advance as normal), then → HALT. If that was the final op, done pulses and the next state is IDLE, not HALT.
  - HALT: start → RUN (resume at current head and current counter); clear → IDLE.
- clear (any state) has priority over start and over a simultaneous push: FIFO emptied, counter=0, → IDLE, no done pulse.
- cout_cnt increments at each posedge with issue=1 && acc_cout=1. It saturates at 255 and is cleared only by reset.
- Latency: start at edge N → first issue in cycle N+1. A command with rpt=R occupies R+1 consecutive issue cycles with no bubbles between commands.
- Pointers wrap modulo DEPTH. level is exact 0..DEPTH.
- Reset mid-RUN aborts immediately: outputs return to NOP within the reset assertion, with no done pulse.

Test Plan:
- Push 3 cmds {10110,b=0011,rpt=0},{10110,0001,rpt=2},{10110,0010,rpt=0}, start → issue high exactly 5 consecutive cycles with b sequence 3,1,1,1,2; done pulses with last op; level 3→0; ctrl=11111 before and after.
- Push DEPTH=8 cmds → in_ready=0, level=8; 9th in_valid ignored; after start, first pop restores in_ready next cycle; all 8 issued in order, pointers wrap correctly over two fill/drain rounds.
- halt_en=1, drive acc_cout=1 on 2nd issue cycle of a 4-cycle program → halted=1 next cycle, ctrl=NOP, cout_cnt=1; start → remaining 2 ops issue, done pulses; with halt_en=0 no halt, cout_cnt still counts.
- clear asserted in RUN with 2 cmds pending and simultaneous push → level=0, IDLE, no done, issue=0 next cycle.
- rst_n low mid-RUN (async, between edges) → ctrl=11111, b=0, busy=0, level=0, cout_cnt=0 immediately; start with empty FIFO afterwards keeps IDLE.
- acc_cout held 1 for 300 issue cycles (rpt chains, halt_en=0) → cout_cnt saturates at 255.
